// File: rtl/time_tag_pulse_gen.sv
// Timed-pulse transmitter: free-running tick/period timebase plus an armable
// compare that emits a fixed-width registered pulse on the local timebase.
module time_tag_pulse_gen #(
    parameter int CNT_WIDTH   = 27,
    parameter int PERIOD      = 120000000,
    parameter int PULSE_WIDTH = 12,
    parameter int SEC_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 cmp_valid,
    input  logic [CNT_WIDTH-1:0] cmp_value,
    output logic                 cmp_ready,
    output logic                 cmp_err,
    output logic                 pulse_out,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] tick_count,
    output logic [SEC_WIDTH-1:0] period_count
);

    localparam int WW = $clog2(PULSE_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] TICK_LAST  = CNT_WIDTH'(PERIOD - 1);
    localparam logic [CNT_WIDTH:0]   PERIOD_LIM = (CNT_WIDTH + 1)'(PERIOD);
    localparam logic [WW-1:0]        W_LOAD     = WW'(PULSE_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PULSE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] cmp_reg;
    logic [CNT_WIDTH-1:0] cmp_reg_next;
    logic [WW-1:0]        width_cnt;
    logic [WW-1:0]        width_next;
    logic                 pulse_next;
    logic                 err_next;
    logic                 transfer;

    assign cmp_ready = reset & enable & (state == IDLE);
    assign busy      = (state != IDLE);
    assign transfer  = cmp_valid & cmp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_count   <= '0;
            period_count <= '0;
        end else if (!enable) begin
            tick_count   <= '0;
            period_count <= '0;
        end else if (tick_count == TICK_LAST) begin
            tick_count   <= '0;
            period_count <= period_count + SEC_WIDTH'(1);
        end else begin
            tick_count   <= tick_count + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cmp_reg   <= '0;
            width_cnt <= '0;
            pulse_out <= 1'b0;
            cmp_err   <= 1'b0;
        end else begin
            state     <= state_next;
            cmp_reg   <= cmp_reg_next;
            width_cnt <= width_next;
            pulse_out <= pulse_next;
            cmp_err   <= err_next;
        end
    end

    // Match is only checked while ARMED, so a compare equal to the tick on
    // the arming edge is missed and fires one full period later.
    always_comb begin
        state_next   = state;
        cmp_reg_next = cmp_reg;
        width_next   = width_cnt;
        pulse_next   = 1'b0;
        err_next     = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (transfer) begin
                        if ({1'b0, cmp_value} < PERIOD_LIM) begin
                            cmp_reg_next = cmp_value;
                            state_next   = ARMED;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (tick_count == cmp_reg) begin
                        state_next = PULSE;
                        pulse_next = 1'b1;
                        width_next = W_LOAD;
                    end
                end
                PULSE: begin
                    if (width_cnt == '0) begin
                        state_next = IDLE;
                    end else begin
                        width_next = width_cnt - WW'(1);
                        pulse_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule
